// File: rtl/parking_gate_ctrl_if.sv
// Purpose: lane and counter signal bundle for parking_gate_ctrl.
// Signals:
//   ent_req, ent_a, ent_b   entry lane button and beams (a = street side, b = lot side)
//   ext_req, ext_a, ext_b   exit lane button and beams (a = lot side, b = street side)
//   enter, exit             1-cycle counter pulses, never asserted together
//   gate_in_open/out_open   gate drives, 1 = open
//   occupancy, full, empty  mirror occupancy and its decodes
//   seq_err                 1-cycle pulse on an illegal beam pattern or an exit while empty
// Modports: master drives the lane inputs; slave is the controller.
interface parking_gate_ctrl_if #(
  parameter int OCC_W = 8
);
  logic             ent_req;
  logic             ent_a;
  logic             ent_b;
  logic             ext_req;
  logic             ext_a;
  logic             ext_b;
  logic             enter;
  logic             exit;
  logic             gate_in_open;
  logic             gate_out_open;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             seq_err;

  modport master (
    output ent_req, ent_a, ent_b, ext_req, ext_a, ext_b,
    input  enter, exit, gate_in_open, gate_out_open, occupancy, full, empty, seq_err
  );

  modport slave (
    input  ent_req, ent_a, ent_b, ext_req, ext_a, ext_b,
    output enter, exit, gate_in_open, gate_out_open, occupancy, full, empty, seq_err
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Purpose: parking lot gate controller. One lane FSM per gate recognises a
// complete car passage; an arbiter turns passages into exclusive enter/exit
// pulses and keeps a mirror occupancy that refuses entry when the lot is full.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    parking_gate_ctrl_if.slave (lane inputs, pulses, gates, occupancy)
//
// Lane FSM states:
//   state     | meaning
//   ST_IDLE   | gate closed, waiting for a request
//   ST_OPEN   | gate open, no car in the beams, timeout running
//   ST_A      | car breaks the outer beam only
//   ST_AB     | car breaks both beams
//   ST_B      | car breaks the inner beam only
//   ST_COMMIT | passage complete, one-cycle commit, gate still open

module parking_gate_lane #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_allow,
  input  logic i_a,
  input  logic i_b,
  output logic o_gate,
  output logic o_commit,
  output logic o_err
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPEN, ST_A, ST_AB, ST_B, ST_COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tmr;
  logic          r_gate;
  logic          w_err;
  logic [1:0]    w_ab;

  assign w_ab = {i_a, i_b};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_gate  <= 1'b0;
    end else begin
      r_state <= w_next;
      // gate drive follows the state it is entering, so it lines up with r_state
      r_gate  <= (w_next != ST_IDLE);
      // timeout restarts every time OPEN is (re)entered
      if (w_next == ST_OPEN && r_state != ST_OPEN)
        r_tmr <= TMR_LOAD;
      else if (r_state == ST_OPEN && r_tmr != '0)
        r_tmr <= r_tmr - TW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE: if (i_req && i_allow) w_next = ST_OPEN;
      ST_OPEN: begin
        if (w_ab == 2'b10) begin
          w_next = ST_A;
        end else begin
          if (i_b) w_err = 1'b1;
          if (r_tmr == '0) w_next = ST_IDLE;
        end
      end
      ST_A: begin
        case (w_ab)
          2'b11:   w_next = ST_AB;
          2'b00:   w_next = ST_OPEN;
          2'b01:   w_err  = 1'b1;
          default: w_next = ST_A;
        endcase
      end
      ST_AB: begin
        case (w_ab)
          2'b01:   w_next = ST_B;
          2'b10:   w_next = ST_A;
          2'b00: begin
            w_err  = 1'b1;
            w_next = ST_OPEN;
          end
          default: w_next = ST_AB;
        endcase
      end
      ST_B: begin
        case (w_ab)
          2'b00:   w_next = ST_COMMIT;
          2'b11:   w_next = ST_AB;
          2'b10:   w_err  = 1'b1;
          default: w_next = ST_B;
        endcase
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign o_gate   = r_gate;
  assign o_commit = (r_state == ST_COMMIT);
  assign o_err    = w_err;
endmodule

module parking_gate_ctrl #(
  parameter int CAPACITY = 20,
  parameter int OCC_W    = 8,
  parameter int TIMEOUT  = 1000
) (
  input logic               clk,
  input logic               reset,
  parking_gate_ctrl_if.slave bus
);
  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic             r_enter;
  logic             r_exit;
  logic             r_ext_pend;
  logic             r_seq_err;
  logic [OCC_W-1:0] r_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_ent_commit;
  logic             w_ext_commit;
  logic             w_ent_err;
  logic             w_ext_err;
  logic             w_ext_go;
  logic             w_ext_ok;

  assign w_full  = (r_occ == CAP);
  assign w_empty = (r_occ == '0);

  parking_gate_lane #(.TIMEOUT(TIMEOUT)) u_ent (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.ent_req),
    .i_allow  (~w_full),
    .i_a      (bus.ent_a),
    .i_b      (bus.ent_b),
    .o_gate   (bus.gate_in_open),
    .o_commit (w_ent_commit),
    .o_err    (w_ent_err)
  );

  parking_gate_lane #(.TIMEOUT(TIMEOUT)) u_ext (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.ext_req),
    .i_allow  (1'b1),
    .i_a      (bus.ext_a),
    .i_b      (bus.ext_b),
    .o_gate   (bus.gate_out_open),
    .o_commit (w_ext_commit),
    .o_err    (w_ext_err)
  );

  // An exit commit colliding with an entry commit is deferred one cycle.
  // A lane cannot commit on two consecutive cycles, so the deferred exit
  // never meets a fresh entry or exit commit.
  assign w_ext_go = (w_ext_commit & ~w_ent_commit) | r_ext_pend;
  // r_occ already includes any earlier entry, so an exit is judged against it
  assign w_ext_ok = w_ext_go & ~w_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enter    <= 1'b0;
      r_exit     <= 1'b0;
      r_ext_pend <= 1'b0;
      r_seq_err  <= 1'b0;
      r_occ      <= '0;
    end else begin
      r_enter    <= w_ent_commit;
      r_exit     <= w_ext_ok;
      r_ext_pend <= w_ext_commit & w_ent_commit;
      r_seq_err  <= w_ent_err | w_ext_err | (w_ext_go & w_empty);
      if (w_ent_commit && !w_ext_ok)
        r_occ <= r_occ + OCC_W'(1);
      else if (w_ext_ok && !w_ent_commit)
        r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign bus.enter     = r_enter;
  assign bus.exit      = r_exit;
  assign bus.seq_err   = r_seq_err;
  assign bus.occupancy = r_occ;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;
  localparam int CAPACITY = 20;
  localparam int OCC_W    = 8;
  localparam int TIMEOUT  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_gate_ctrl_if #(.OCC_W(OCC_W)) bus();

  parking_gate_ctrl #(
    .CAPACITY (CAPACITY),
    .OCC_W    (OCC_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // pulse monitor, sampled on the falling edge
  int cyc = 0;
  int enter_cnt = 0, exit_cnt = 0, seqerr_cnt = 0, both_cnt = 0;
  int enter_cyc = 0, exit_cyc = 0, occ_at_enter = 0, occ_at_exit = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.enter === 1'b1) begin
      enter_cnt    <= enter_cnt + 1;
      enter_cyc    <= cyc;
      occ_at_enter <= int'(bus.occupancy);
    end
    if (bus.exit === 1'b1) begin
      exit_cnt    <= exit_cnt + 1;
      exit_cyc    <= cyc;
      occ_at_exit <= int'(bus.occupancy);
    end
    if (bus.seq_err === 1'b1) seqerr_cnt <= seqerr_cnt + 1;
    if (bus.enter === 1'b1 && bus.exit === 1'b1) both_cnt <= both_cnt + 1;
  end

  // reference model: lot-level bookkeeping of completed passages
  int occ_m = 0, enter_m = 0, exit_m = 0, seqerr_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_beams(input bit en, input bit ex, input bit a, input bit b);
    if (en) begin bus.ent_a = a; bus.ent_b = b; end
    if (ex) begin bus.ext_a = a; bus.ext_b = b; end
  endtask

  task automatic passage(input bit en, input bit ex, input int hold, input bit backout);
    if (en) bus.ent_req = 1'b1;
    if (ex) bus.ext_req = 1'b1;
    tick();
    bus.ent_req = 1'b0;
    bus.ext_req = 1'b0;
    set_beams(en, ex, 1'b1, 1'b0); ticks(hold);
    set_beams(en, ex, 1'b1, 1'b1); ticks(hold);
    if (backout) set_beams(en, ex, 1'b1, 1'b0);
    else         set_beams(en, ex, 1'b0, 1'b1);
    ticks(hold);
    set_beams(en, ex, 1'b0, 1'b0);
    if (backout) ticks(TIMEOUT + 2);
    else         ticks(4);
  endtask

  task automatic model_entry();
    occ_m++;
    enter_m++;
  endtask

  task automatic model_exit();
    if (occ_m > 0) begin
      occ_m--;
      exit_m++;
    end else begin
      seqerr_m++;
    end
  endtask

  task automatic check_totals(input string tag);
    chk({tag, "_occ"},      32'(bus.occupancy),     32'(occ_m));
    chk({tag, "_enters"},   32'(enter_cnt),         32'(enter_m));
    chk({tag, "_exits"},    32'(exit_cnt),          32'(exit_m));
    chk({tag, "_seqerr"},   32'(seqerr_cnt),        32'(seqerr_m));
    chk({tag, "_both"},     32'(both_cnt),          32'd0);
    chk({tag, "_full"},     32'(bus.full),          32'(occ_m == CAPACITY));
    chk({tag, "_empty"},    32'(bus.empty),         32'(occ_m == 0));
    chk({tag, "_gate_in"},  32'(bus.gate_in_open),  32'd0);
    chk({tag, "_gate_out"}, 32'(bus.gate_out_open), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int opened;
    int op;
    int hold;
    bus.ent_req = 1'b0; bus.ent_a = 1'b0; bus.ent_b = 1'b0;
    bus.ext_req = 1'b0; bus.ext_a = 1'b0; bus.ext_b = 1'b0;

    // 1: reset, then idle
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(10);
    check_totals("t1");

    // 2: complete entry passage
    bus.ent_req = 1'b1;
    tick();
    chk("t2_gate_after_req", 32'(bus.gate_in_open), 32'd1);
    bus.ent_req = 1'b0;
    set_beams(1, 0, 1, 0); ticks(3);
    set_beams(1, 0, 1, 1); ticks(3);
    set_beams(1, 0, 0, 1); ticks(3);
    set_beams(1, 0, 0, 0);
    tick();
    chk("t2_gate_in_commit", 32'(bus.gate_in_open), 32'd1);
    ticks(2);
    chk("t2_gate_closed", 32'(bus.gate_in_open), 32'd0);
    tick();
    model_entry();
    check_totals("t2");

    // 3: back-out, gate closes after the restarted timeout
    bus.ent_req = 1'b1;
    tick();
    bus.ent_req = 1'b0;
    set_beams(1, 0, 1, 0); ticks(3);
    set_beams(1, 0, 1, 1); ticks(3);
    set_beams(1, 0, 1, 0); ticks(3);
    set_beams(1, 0, 0, 0);
    tick();
    chk("t3_gate_back_open", 32'(bus.gate_in_open), 32'd1);
    ticks(TIMEOUT - 1);
    chk("t3_gate_last_open", 32'(bus.gate_in_open), 32'd1);
    tick();
    chk("t3_gate_timeout", 32'(bus.gate_in_open), 32'd0);
    check_totals("t3");

    // 4: fill the lot, then requests are refused
    while (occ_m < CAPACITY) begin
      passage(1, 0, 2, 0);
      model_entry();
    end
    check_totals("t4_filled");
    opened = 0;
    bus.ent_req = 1'b1;
    repeat (50) begin
      tick();
      if (bus.gate_in_open !== 1'b0) opened++;
    end
    bus.ent_req = 1'b0;
    tick();
    chk("t4_gate_refused", 32'(opened), 32'd0);
    check_totals("t4");

    // 5: drain to 5, then simultaneous commits
    while (occ_m > 5) begin
      passage(0, 1, 1, 0);
      model_exit();
    end
    check_totals("t5_pre");
    passage(1, 1, 2, 0);
    model_entry();
    model_exit();
    chk("t5_exit_after_enter", 32'(exit_cyc - enter_cyc), 32'd1);
    chk("t5_occ_at_enter", 32'(occ_at_enter), 32'd6);
    chk("t5_occ_at_exit", 32'(occ_at_exit), 32'd5);
    check_totals("t5");

    // 6: exit while empty
    while (occ_m > 0) begin
      passage(0, 1, 1, 0);
      model_exit();
    end
    passage(0, 1, 2, 0);
    model_exit();
    check_totals("t6");

    // 7: reset in the middle of a passage
    passage(1, 0, 1, 0);
    model_entry();
    check_totals("t7_pre");
    bus.ent_req = 1'b1;
    tick();
    bus.ent_req = 1'b0;
    set_beams(1, 0, 1, 0); ticks(2);
    set_beams(1, 0, 1, 1); ticks(2);
    reset = 1'b0;
    tick();
    chk("t7_gate_after_reset", 32'(bus.gate_in_open), 32'd0);
    chk("t7_occ_after_reset", 32'(bus.occupancy), 32'd0);
    set_beams(1, 0, 0, 0);
    reset = 1'b1;
    occ_m = 0;
    ticks(5);
    check_totals("t7");

    // randomized passages against the lot-level model
    repeat (40) begin
      op   = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 3));
      case (op)
        0, 1: begin
          if (occ_m == CAPACITY) begin
            bus.ent_req = 1'b1;
            ticks(3);
            chk("rand_refused", 32'(bus.gate_in_open), 32'd0);
            bus.ent_req = 1'b0;
            tick();
          end else begin
            passage(1, 0, hold, 0);
            model_entry();
          end
        end
        2: if (occ_m < CAPACITY) passage(1, 0, hold, 1);
        default: begin
          passage(0, 1, hold, 0);
          model_exit();
        end
      endcase
      ticks(int'($urandom_range(0, 3)));
      check_totals("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
